// File: rtl/counter_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// counter_cmd_arbiter
//
// Two-requester command scheduler that owns a single mod-N up/down counter.
// Each requester submits a command (direction + step count). Commands are
// arbitrated round-robin, captured one at a time, and executed by stepping the
// counter once per cycle. The owner receives a one-cycle done pulse when its
// command completes.
//
// Optional feature macro: COUNT_ARB_ABORT_EN
//   When defined, adds i_abort / o_aborted so a running command can be cut
//   short (counter keeps its partial value, o_aborted pulses with o_done).
//
// Parameters:
//   WIDTH  width of o_Q (2**WIDTH >= N)
//   N      counter modulus (N >= 2), o_Q stays within 0..N-1
//   SW     width of each per-command step count
//
// Ports:
//   i_clk       clock, all state updates on the rising edge
//   i_rst       synchronous active-high reset
//   i_req       per-requester command request (bit k = requester k)
//   i_up_down   per-requester direction, 1 = increment, 0 = decrement
//   i_steps     per-requester step counts, requester k uses [k*SW +: SW]
//   i_abort     (COUNT_ARB_ABORT_EN) terminate the running command
//   o_gnt       one-hot pulse: command of requester k captured
//   o_done      one-hot pulse: command of requester k finished
//   o_aborted   (COUNT_ARB_ABORT_EN) pulses with o_done on an aborted command
//   o_busy      high while a command is in progress (state != IDLE)
//   o_wrap      pulse in the cycle after a modulus wrap step
//   o_Q         current counter value
// -----------------------------------------------------------------------------
module counter_cmd_arbiter #(
  parameter int WIDTH = 3,
  parameter int N     = 5,
  parameter int SW    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_req,
  input  logic [1:0]       i_up_down,
  input  logic [2*SW-1:0]  i_steps,
`ifdef COUNT_ARB_ABORT_EN
  input  logic             i_abort,
  output logic             o_aborted,
`endif
  output logic [1:0]       o_gnt,
  output logic [1:0]       o_done,
  output logic             o_busy,
  output logic             o_wrap,
  output logic [WIDTH-1:0] o_Q
);

  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t          r_state;
  logic            r_ptr;        // round-robin preference: requester to favour next
  logic            r_owner;      // requester whose command is in flight
  logic            r_up;         // captured direction
  logic [SW-1:0]   r_remaining;  // steps still to perform

  logic            w_win;
  logic            w_win_up;
  logic [SW-1:0]   w_win_steps;
  logic [WIDTH-1:0] w_q_next;
  logic            w_wrap_step;

  function automatic logic [1:0] onehot(input logic k);
    return k ? 2'b10 : 2'b01;
  endfunction

  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (here by unconditional assignment first), otherwise a latch is inferred.
  always_comb begin
    w_win       = i_req[r_ptr] ? r_ptr : ~r_ptr;
    w_win_up    = i_up_down[w_win];
    w_win_steps = w_win ? i_steps[2*SW-1:SW] : i_steps[SW-1:0];
    w_wrap_step = 1'b0;
    w_q_next    = o_Q;
    if (r_up) begin
      w_wrap_step = (o_Q == Q_MAX);
      w_q_next    = w_wrap_step ? '0 : o_Q + WIDTH'(1);
    end else begin
      w_wrap_step = (o_Q == '0);
      w_q_next    = w_wrap_step ? Q_MAX : o_Q - WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 1'b0;
      r_owner     <= 1'b0;
      r_up        <= 1'b0;
      r_remaining <= '0;
      o_gnt       <= 2'b00;
      o_done      <= 2'b00;
      o_busy      <= 1'b0;
      o_wrap      <= 1'b0;
      o_Q         <= '0;
`ifdef COUNT_ARB_ABORT_EN
      o_aborted   <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; only the transitions below raise them.
      o_gnt  <= 2'b00;
      o_done <= 2'b00;
      o_wrap <= 1'b0;
`ifdef COUNT_ARB_ABORT_EN
      o_aborted <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (|i_req) begin
            r_owner     <= w_win;
            r_up        <= w_win_up;
            r_remaining <= w_win_steps;
            o_gnt       <= onehot(w_win);
            o_busy      <= 1'b1;
            // A zero-step command finishes immediately: grant and done coincide.
            if (w_win_steps == '0) begin
              r_state <= ST_DONE;
              o_done  <= onehot(w_win);
            end else begin
              r_state <= ST_RUN;
            end
          end else begin
            o_busy <= 1'b0;
          end
        end

        ST_RUN: begin
          o_busy <= 1'b1;
`ifdef COUNT_ARB_ABORT_EN
          if (i_abort) begin
            // Abort skips this edge's step; o_Q keeps its partial value.
            r_state   <= ST_DONE;
            o_done    <= onehot(r_owner);
            o_aborted <= 1'b1;
          end else
`endif
          begin
            o_Q         <= w_q_next;
            o_wrap      <= w_wrap_step;
            r_remaining <= r_remaining - SW'(1);
            if (r_remaining == SW'(1)) begin
              r_state <= ST_DONE;
              o_done  <= onehot(r_owner);
            end
          end
        end

        ST_DONE: begin
          r_ptr   <= ~r_owner;
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_counter_cmd_arbiter
//
// Directed bench for counter_cmd_arbiter. A transaction-level model tracks the
// command in flight as (capture point, start value, step budget) and derives
// every output arithmetically from the number of edges since capture. All DUT
// outputs are compared with the model after every clock edge; a handful of
// literal expectations pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_counter_cmd_arbiter;

  localparam int WIDTH = 3;
  localparam int N     = 5;
  localparam int SW    = 4;

  logic             clk = 1'b0;
  logic             i_rst;
  logic [1:0]       i_req;
  logic [1:0]       i_up_down;
  logic [2*SW-1:0]  i_steps;
  logic [1:0]       o_gnt;
  logic [1:0]       o_done;
  logic             o_busy;
  logic             o_wrap;
  logic [WIDTH-1:0] o_Q;
`ifdef COUNT_ARB_ABORT_EN
  logic             i_abort;
  logic             o_aborted;
`endif

  always #5 clk = ~clk;

  counter_cmd_arbiter #(.WIDTH(WIDTH), .N(N), .SW(SW)) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_req     (i_req),
    .i_up_down (i_up_down),
    .i_steps   (i_steps),
`ifdef COUNT_ARB_ABORT_EN
    .i_abort   (i_abort),
    .o_aborted (o_aborted),
`endif
    .o_gnt     (o_gnt),
    .o_done    (o_done),
    .o_busy    (o_busy),
    .o_wrap    (o_wrap),
    .o_Q       (o_Q)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- model ----------------
  bit m_active = 1'b0;
  int m_k      = 0;     // edges since capture (0 = cycle right after capture)
  int m_q      = 0;     // counter value
  int m_q0     = 0;     // value at capture
  int m_nmax   = 0;     // steps this command performs
  int m_dend   = 0;     // edge index at which done is shown
  int m_owner  = 0;
  int m_ptr    = 0;
  bit m_up     = 1'b0;
  bit m_ab     = 1'b0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int q_after(input int n);
    if (m_up) return (m_q0 + n) % N;
    return ((m_q0 - n) % N + N) % N;
  endfunction

  function automatic bit model_idle();
    return !m_active || (m_k > m_dend);
  endfunction

  task automatic model_edge();
    if (i_rst) begin
      m_active = 1'b0;
      m_q      = 0;
      m_ptr    = 0;
      return;
    end
    if (m_active) begin
      m_k++;
`ifdef COUNT_ARB_ABORT_EN
      if (i_abort && !m_ab && m_k <= m_nmax) begin
        m_nmax = m_k - 1;
        m_dend = m_k;
        m_ab   = 1'b1;
      end
`endif
      m_q = q_after(imin(m_k, m_nmax));
      if (m_k == m_dend + 1) m_ptr = 1 - m_owner;
      if (m_k >= m_dend + 2) m_active = 1'b0;
    end
    if (!m_active && i_req != 2'b00) begin
      m_owner  = i_req[m_ptr] ? m_ptr : 1 - m_ptr;
      m_q0     = m_q;
      m_nmax   = int'(i_steps[m_owner*SW +: SW]);
      m_dend   = m_nmax;
      m_up     = i_up_down[m_owner];
      m_ab     = 1'b0;
      m_k      = 0;
      m_active = 1'b1;
    end
  endtask

  task automatic compare();
    int e_gnt, e_done, e_busy, e_wrap, e_ab, pre;
    e_gnt = 0; e_done = 0; e_busy = 0; e_wrap = 0; e_ab = 0;
    if (m_active) begin
      if (m_k == 0)      e_gnt  = 1 << m_owner;
      if (m_k == m_dend) e_done = 1 << m_owner;
      if (m_k == m_dend) e_ab   = int'(m_ab);
      e_busy = int'(m_k <= m_dend);
      if (m_k >= 1 && m_k <= m_nmax) begin
        pre    = q_after(m_k - 1);
        e_wrap = m_up ? int'(pre == N - 1) : int'(pre == 0);
      end
    end
    check("o_Q",    int'(o_Q),    m_q);
    check("o_gnt",  int'(o_gnt),  e_gnt);
    check("o_done", int'(o_done), e_done);
    check("o_busy", int'(o_busy), e_busy);
    check("o_wrap", int'(o_wrap), e_wrap);
`ifdef COUNT_ARB_ABORT_EN
    check("o_aborted", int'(o_aborted), e_ab);
`endif
  endtask

  // ---------------- stimulus helpers ----------------
  int cyc       = 0;
  int gnt_cyc   = -1;
  int done_cyc  = -1;
  int wrap_seen = 0;

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    cyc++;
    if (o_gnt  != 2'b00) gnt_cyc  = cyc;
    if (o_done != 2'b00) done_cyc = cyc;
    if (o_wrap) wrap_seen++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!model_idle() && n < 60) begin
      step();
      n++;
    end
    check("idle_timeout", int'(model_idle()), 1);
  endtask

  task automatic wait_grant(input int k);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(m_active && m_k == 0 && m_owner == k) && n < 20);
    check("gnt_timeout", int'(n < 20), 1);
  endtask

  task automatic post_cmd(input int k, input bit up, input int s);
    i_req[k]               = 1'b1;
    i_up_down[k]           = up;
    i_steps[k*SW +: SW]    = s[SW-1:0];
  endtask

  task automatic run_cmd(input int k, input bit up, input int s);
    post_cmd(k, up, s);
    wait_grant(k);
    i_req[k] = 1'b0;
    wait_idle();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int owners[$];
    int gcycles[$];
    int q_before;

    i_rst = 1'b1; i_req = 2'b00; i_up_down = 2'b00; i_steps = '0;
`ifdef COUNT_ARB_ABORT_EN
    i_abort = 1'b0;
`endif
    step();
    step();
    check("rst_q", int'(o_Q), 0);
    check("rst_busy", int'(o_busy), 0);
    i_rst = 1'b0;
    step();

    // 1: req0 up 3 -> 1,2,3; done three cycles after grant
    wrap_seen = 0;
    run_cmd(0, 1'b1, 3);
    check("t1_q", int'(o_Q), 3);
    check("t1_gnt_to_done", done_cyc - gnt_cyc, 3);
    check("t1_wraps", wrap_seen, 0);

    // 2: req1 up 4 from 3 -> 4,0,1,2 with one wrap
    wrap_seen = 0;
    run_cmd(1, 1'b1, 4);
    check("t2_q", int'(o_Q), 2);
    check("t2_wraps", wrap_seen, 1);

    // bring counter to 0, then 3: req0 down 2 from 0 -> 4,3 with one wrap
    run_cmd(0, 1'b0, 2);
    check("t3_pre_q", int'(o_Q), 0);
    wrap_seen = 0;
    run_cmd(0, 1'b0, 2);
    check("t3_q", int'(o_Q), 3);
    check("t3_wraps", wrap_seen, 1);

    // 4: reset, then both requesting continuously with one step each
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    post_cmd(0, 1'b1, 1);
    post_cmd(1, 1'b1, 1);
    for (int i = 0; i < 14; i++) begin
      step();
      if (o_gnt != 2'b00) begin
        owners.push_back(int'(o_gnt[1]));
        gcycles.push_back(i);
      end
    end
    i_req = 2'b00;
    wait_idle();
    check("t4_ngrants", owners.size(), 5);
    for (int i = 0; i < 4 && i < owners.size(); i++) begin
      check("t4_owner", owners[i], i % 2);
      if (i > 0) check("t4_spacing", gcycles[i] - gcycles[i-1], 3);
    end

    // 5: zero-step command, grant and done in the same cycle, Q unchanged
    q_before = m_q;
    run_cmd(0, 1'b1, 0);
    check("t5_gnt_eq_done", done_cyc - gnt_cyc, 0);
    check("t5_q", int'(o_Q), q_before);
    check("t5_busy_after", int'(o_busy), 0);

    // 6: pointer now favours requester 1; reset mid-run of a 10-step command
    post_cmd(1, 1'b1, 10);
    wait_grant(1);
    i_req[1] = 1'b0;
    step(); step(); step();
    i_rst = 1'b1;
    step();
    check("t6_rst_q", int'(o_Q), 0);
    check("t6_rst_busy", int'(o_busy), 0);
    i_rst = 1'b0;
    step();
    check("t6_no_done", int'(o_done), 0);
    // after reset the pointer favours requester 0 under contention
    post_cmd(0, 1'b1, 1);
    post_cmd(1, 1'b1, 1);
    wait_grant(0);
    check("t6_ptr_gnt", int'(o_gnt), 1);
    i_req = 2'b00;
    wait_idle();

`ifdef COUNT_ARB_ABORT_EN
    // abort after two steps: Q frozen, done and aborted together
    q_before = m_q;
    post_cmd(0, 1'b1, 5);
    wait_grant(0);
    i_req[0] = 1'b0;
    step(); step();
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("ab_done", int'(o_done), 1);
    check("ab_aborted", int'(o_aborted), 1);
    check("ab_q", int'(o_Q), (q_before + 2) % N);
    wait_idle();
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
